// File: rtl/ucsbece154b_mem_arbiter_pkg.sv
// ucsbece154b_mem_arbiter_pkg: shared state encodings, requester indices and block size
package ucsbece154b_mem_arbiter_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] BURST = 2'd2;
  localparam int REQ_IC = 0;
  localparam int REQ_DC = 1;
  localparam int BLOCK_SIZE_DEFAULT = 4;
endpackage

// File: rtl/ucsbece154b_mem_arbiter_if.sv
// ucsbece154b_mem_arbiter_if: cache/SDRAM read bus bundle seen by the arbiter
interface ucsbece154b_mem_arbiter_if;
  logic        icReadRequest_i;
  logic [31:0] icReadAddress_i;
  logic        icDataReady_o;
  logic        dcReadRequest_i;
  logic [31:0] dcReadAddress_i;
  logic        dcDataReady_o;
  logic [31:0] dataOut_o;
  logic        sdramReadRequest_o;
  logic [31:0] sdramReadAddress_o;
  logic        sdramDataReady_i;
  logic [31:0] sdramDataIn_i;
  logic [1:0]  grant_o;
  logic        burstError_o;
  modport slave (
    input  icReadRequest_i, icReadAddress_i, dcReadRequest_i, dcReadAddress_i,
           sdramDataReady_i, sdramDataIn_i,
    output icDataReady_o, dcDataReady_o, dataOut_o, sdramReadRequest_o,
           sdramReadAddress_o, grant_o, burstError_o
  );
  modport master (
    output icReadRequest_i, icReadAddress_i, dcReadRequest_i, dcReadAddress_i,
           sdramDataReady_i, sdramDataIn_i,
    input  icDataReady_o, dcDataReady_o, dataOut_o, sdramReadRequest_o,
           sdramReadAddress_o, grant_o, burstError_o
  );
endinterface

// File: rtl/ucsbece154b_rr_arb2.sv
// ucsbece154b_rr_arb2: combinational 2-way round-robin / fixed-priority picker
module ucsbece154b_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       mode_i,
  output logic [1:0] grant_o
);
  // on a tie the icache wins if priority is fixed or the dcache was served last
  always_comb grant_o = (req_i == 2'b11) ? ((mode_i || last_grant_i) ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/ucsbece154b_mem_arbiter.sv
// ucsbece154b_mem_arbiter: shares the SDRAM read bus between icache and dcache,
// holding each grant for a full block burst
module ucsbece154b_mem_arbiter
  import ucsbece154b_mem_arbiter_pkg::*;
#(
  parameter int BLOCK_SIZE     = BLOCK_SIZE_DEFAULT,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input logic clk,
  input logic reset_i,
  ucsbece154b_mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(BLOCK_SIZE);
  logic [1:0]    state_q, state_d, grant_q, grant_d, pick;
  logic [31:0]   addr_q, addr_d, ic_grants_q, ic_grants_d, dc_grants_q, dc_grants_d;
  logic          req_q, req_d, err_q, err_d, last_q, last_d, drdy, active;
  logic [CW-1:0] cnt_q, cnt_d;
  assign drdy   = bus.sdramDataReady_i;
  assign active = (state_q == REQ) || (state_q == BURST);
  ucsbece154b_rr_arb2 u_arb (
    .req_i       ({bus.dcReadRequest_i, bus.icReadRequest_i}),
    .last_grant_i(last_q),
    .mode_i      (FIXED_PRIORITY),
    .grant_o     (pick)
  );
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    req_d       = req_q;
    err_d       = err_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    ic_grants_d = ic_grants_q;
    dc_grants_d = dc_grants_q;
    case (state_q)
      IDLE: if (|pick) begin
        state_d = REQ;
        grant_d = pick;
        addr_d  = pick[REQ_DC] ? bus.dcReadAddress_i : bus.icReadAddress_i;
        req_d   = 1'b1;
      end
      REQ: if (drdy) begin
        state_d = BURST;
        cnt_d   = CW'(1);
        req_d   = 1'b0;
      end
      BURST: if (!drdy || cnt_q == CW'(BLOCK_SIZE - 1)) begin
        state_d     = IDLE;
        grant_d     = 2'b00;
        cnt_d       = '0;
        last_d      = grant_q[REQ_DC];
        err_d       = err_q | !drdy;
        ic_grants_d = ic_grants_q + {31'd0, drdy & grant_q[REQ_IC]};
        dc_grants_d = dc_grants_q + {31'd0, drdy & grant_q[REQ_DC]};
      end else cnt_d = cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      addr_q      <= '0;
      req_q       <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      ic_grants_q <= '0;
      dc_grants_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      err_q       <= err_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      ic_grants_q <= ic_grants_d;
      dc_grants_q <= dc_grants_d;
    end
  end
  assign bus.icDataReady_o      = drdy & grant_q[REQ_IC] & active;
  assign bus.dcDataReady_o      = drdy & grant_q[REQ_DC] & active;
  assign bus.dataOut_o          = bus.sdramDataIn_i;
  assign bus.sdramReadRequest_o = req_q;
  assign bus.sdramReadAddress_o = addr_q;
  assign bus.grant_o            = grant_q;
  assign bus.burstError_o       = err_q;
endmodule
